// File: rtl/bcd_incrementer.sv
// Registered packed-BCD +1 incrementer with carry-out and invalid-digit flag.
// Optional: define BCD_SATURATE_EN to hold an all-9s input instead of wrapping to 0.
module bcd_incrementer #(
  parameter int INPUT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [INPUT_WIDTH-1:0] input_value,
  output logic                   out_valid,
  output logic [INPUT_WIDTH-1:0] out,
  output logic                   carry_out,
  output logic                   digit_err
);

  localparam int NUM_DIGITS = INPUT_WIDTH / 4;

  // Handshake: a result is produced for every edge with in_valid=1; out_valid
  // is high for exactly the cycle after that edge. No backpressure exists.

  logic [INPUT_WIDTH-1:0] sum;
  logic [3:0]             digit;
  logic                   ripple;
  logic                   all_nines;
  logic                   err_d;
  logic [INPUT_WIDTH-1:0] out_d;
  logic                   carry_d;

  logic                   out_valid_q;
  logic [INPUT_WIDTH-1:0] out_q;
  logic                   carry_q;
  logic                   err_q;

  // Full combinational decimal ripple; carry-in to digit 0 is the +1.
  always_comb begin
    sum       = input_value;
    digit     = 4'd0;
    ripple    = 1'b1;
    all_nines = 1'b1;
    err_d     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit = input_value[4*i +: 4];
      if (digit > 4'd9) err_d = 1'b1;
      if (digit != 4'd9) all_nines = 1'b0;
      if (ripple) begin
        if (digit == 4'd9) begin
          sum[4*i +: 4] = 4'd0;
        end else begin
          sum[4*i +: 4] = digit + 4'd1;
          ripple        = 1'b0;
        end
      end
    end
  end

  // Invalid digits pass through untouched rather than a partial increment.
  always_comb begin
    out_d   = sum;
    carry_d = ripple;
    if (err_d) begin
      out_d   = input_value;
      carry_d = 1'b0;
    end
`ifdef BCD_SATURATE_EN
    else if (all_nines) begin
      out_d   = input_value;
      carry_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_q   <= out_d;
        carry_q <= carry_d;
        err_q   <= err_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign carry_out = carry_q;
  assign digit_err = err_q;

endmodule

// File: tb/tb_bcd_incrementer.sv
// Directed bench for bcd_incrementer at 16-bit and 8-bit widths.
module tb_bcd_incrementer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] input_value;
  logic        out_valid;
  logic [15:0] out;
  logic        carry_out;
  logic        digit_err;

  logic        in_valid8;
  logic [7:0]  input_value8;
  logic        out_valid8;
  logic [7:0]  out8;
  logic        carry_out8;
  logic        digit_err8;

  int compared = 0;
  int mismatched = 0;

  bcd_incrementer #(.INPUT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .input_value(input_value),
    .out_valid(out_valid), .out(out), .carry_out(carry_out), .digit_err(digit_err)
  );

  bcd_incrementer #(.INPUT_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .input_value(input_value8),
    .out_valid(out_valid8), .out(out8), .carry_out(carry_out8), .digit_err(digit_err8)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic drive16(input logic [15:0] v);
    @(negedge clk);
    in_valid    = 1'b1;
    input_value = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle16();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [7:0] v);
    @(negedge clk);
    in_valid8    = 1'b1;
    input_value8 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] e_out, input logic e_c,
                       input logic e_err, input logic e_v);
    chk({tag, "_out"}, {16'h0, out}, {16'h0, e_out});
    chk({tag, "_carry"}, {31'h0, carry_out}, {31'h0, e_c});
    chk({tag, "_err"}, {31'h0, digit_err}, {31'h0, e_err});
    chk({tag, "_valid"}, {31'h0, out_valid}, {31'h0, e_v});
  endtask

  task automatic chk8(input string tag, input logic [7:0] e_out, input logic e_c,
                      input logic e_err, input logic e_v);
    chk({tag, "_out"}, {24'h0, out8}, {24'h0, e_out});
    chk({tag, "_carry"}, {31'h0, carry_out8}, {31'h0, e_c});
    chk({tag, "_err"}, {31'h0, digit_err8}, {31'h0, e_err});
    chk({tag, "_valid"}, {31'h0, out_valid8}, {31'h0, e_v});
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    input_value  = 16'h0;
    in_valid8    = 1'b0;
    input_value8 = 8'h0;
    #2;
    chk16("reset_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk16("after_release", 16'h0000, 1'b0, 1'b0, 1'b0);

    // back-to-back basics
    drive16(16'h8898); chk16("b2b_8898", 16'h8899, 1'b0, 1'b0, 1'b1);
    drive16(16'h1235); chk16("b2b_1235", 16'h1236, 1'b0, 1'b0, 1'b1);
    drive16(16'h0000); chk16("b2b_0000", 16'h0001, 1'b0, 1'b0, 1'b1);

    // hold while idle
    drive16(16'h8898); chk16("pre_idle", 16'h8899, 1'b0, 1'b0, 1'b1);
    idle16(); chk16("idle1", 16'h8899, 1'b0, 1'b0, 1'b0);
    idle16(); chk16("idle2", 16'h8899, 1'b0, 1'b0, 1'b0);
    idle16(); chk16("idle3", 16'h8899, 1'b0, 1'b0, 1'b0);

    // ripple carry
    drive16(16'h7999); chk16("rip_7999", 16'h8000, 1'b0, 1'b0, 1'b1);
    drive16(16'h1999); chk16("rip_1999", 16'h2000, 1'b0, 1'b0, 1'b1);
    drive16(16'h0990); chk16("rip_0990", 16'h0991, 1'b0, 1'b0, 1'b1);

    // overflow
    drive16(16'h9999);
`ifdef BCD_SATURATE_EN
    chk16("ovf_9999", 16'h9999, 1'b1, 1'b0, 1'b1);
`else
    chk16("ovf_9999", 16'h0000, 1'b1, 1'b0, 1'b1);
`endif

    // invalid digit, then recovery
    drive16(16'h12A4); chk16("err_12A4", 16'h12A4, 1'b0, 1'b1, 1'b1);
    drive16(16'h0009); chk16("post_err", 16'h0010, 1'b0, 1'b0, 1'b1);
    drive16(16'h9F99); chk16("err_9F99", 16'h9F99, 1'b0, 1'b1, 1'b1);
    idle16(); chk16("err_clear_hold", 16'h9F99, 1'b0, 1'b1, 1'b0);

    // reset mid-operation: in-flight 1235 is discarded
    @(negedge clk);
    in_valid    = 1'b1;
    input_value = 16'h1235;
    #2;
    reset = 1'b1;
    #1;
    chk16("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk16("reset_inflight", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    chk16("reset_done", 16'h0000, 1'b0, 1'b0, 1'b0);

    // 8-bit instance
    drive8(8'h99);
`ifdef BCD_SATURATE_EN
    chk8("w8_99", 8'h99, 1'b1, 1'b0, 1'b1);
`else
    chk8("w8_99", 8'h00, 1'b1, 1'b0, 1'b1);
`endif
    drive8(8'h09); chk8("w8_09", 8'h10, 1'b0, 1'b0, 1'b1);
    drive8(8'h3B); chk8("w8_3B", 8'h3B, 1'b0, 1'b1, 1'b1);
    drive8(8'h48); chk8("w8_48", 8'h49, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
